// File: rtl/ahb_lite_slave_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_pkg
// Brief    : Shared AHB-Lite codes, responder state encoding and byte-lane helper.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Little-endian lane select; illegal sizes enable no lanes.
    function automatic logic [3:0] size_addr_to_be(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = 4'b0011 << {a[1], 1'b0};
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_slave_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahb_resp_mem
// Brief    : Word-wide RAM with byte-enabled synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_resp_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    localparam int c_depth = 2 ** AW;

    // One byte-wide array per lane keeps the write enable a plain per-lane gate.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_lane [c_depth];

        always_ff @(posedge clk) begin
            if (i_we && i_be[l]) begin
                r_lane[i_waddr] <= i_wdata[8*l +: 8];
            end
        end

        assign o_rdata[8*l +: 8] = r_lane[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_slave_responder
// Brief    : AHB-Lite completer backed by local RAM, with programmable wait
//            states and two-cycle ERROR for a window and bad size/alignment.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_slave_responder
    import ahb_lite_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000,
    parameter logic [31:0] ERR_SIZE    = 32'h0000_1000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);
    localparam bit         c_has_wait  = (WAIT_STATES > 0);

    logic [2:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [MEM_AW+1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_size;
    logic              r_err;

    logic        w_accept;
    logic        w_can_accept;
    logic        w_take;
    logic        w_in_window;
    logic        w_bad_size;
    logic        w_misalign;
    logic        w_err;
    logic [2:0]  w_accept_state;
    logic [2:0]  w_state_nxt;
    logic        w_mem_we;
    logic [3:0]  w_mem_be;
    logic [31:0] w_mem_rdata;
    logic        w_unused_hburst;

    // Bursts carry no extra meaning here: each beat stands alone.
    assign w_unused_hburst = ^HBURST;

    assign w_accept     = HSEL && HREADYIN && HTRANS[1];
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_take       = w_accept && w_can_accept;

    // Subtraction form avoids overflow when the window touches the top of memory.
    assign w_in_window = (ERR_SIZE != 32'd0) && (HADDR >= ERR_BASE)
                         && ((HADDR - ERR_BASE) < ERR_SIZE);
    assign w_bad_size  = (HSIZE > HSIZE_WORD);
    assign w_misalign  = ((HSIZE == HSIZE_HALF) && HADDR[0])
                         || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign w_err       = w_in_window || w_bad_size || w_misalign;

    always_comb begin
        w_accept_state = w_err ? ST_ERR1 : ST_DATA;
        if (c_has_wait) begin
            w_accept_state = ST_WAIT;
        end

        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_state_nxt = r_err ? ST_ERR1 : ST_DATA;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = w_accept ? w_accept_state : ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_addr     <= HADDR[MEM_AW+1:0];
                r_write    <= HWRITE;
                r_size     <= HSIZE;
                r_err      <= w_err;
                r_wait_cnt <= c_wait_load;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // Reset wins over a write landing in the same cycle.
    assign w_mem_we = (r_state == ST_DATA) && r_write && !r_err && !HRESET;
    assign w_mem_be = size_addr_to_be(r_size, r_addr[1:0]);

    ahb_resp_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (HCLK),
        .i_we    (w_mem_we),
        .i_be    (w_mem_be),
        .i_waddr (r_addr[MEM_AW+1:2]),
        .i_wdata (HWDATA),
        .i_raddr (r_addr[MEM_AW+1:2]),
        .o_rdata (w_mem_rdata)
    );

    assign HREADYOUT = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (r_state == ST_DATA) ? w_mem_rdata : 32'd0;

endmodule
`default_nettype wire
